// File: rtl/wrr_scheduler.sv
// wrr_scheduler: weighted round-robin pop selection over four virtual-channel FIFOs
module wrr_scheduler #(
    parameter int WEIGHT0 = 4,
    parameter int WEIGHT1 = 3,
    parameter int WEIGHT2 = 2,
    parameter int WEIGHT3 = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       stall,
    input  logic       empty_vchanel0,
    input  logic       empty_vchanel1,
    input  logic       empty_vchanel2,
    input  logic       empty_vchanel3,
    output logic       pop_vchanel0,
    output logic       pop_vchanel1,
    output logic       pop_vchanel2,
    output logic       pop_vchanel3,
    output logic [1:0] arbiter,
    output logic       valid,
    output logic [3:0] grant_cnt
);
    localparam logic [15:0] WTS = {4'(WEIGHT3), 4'(WEIGHT2), 4'(WEIGHT1), 4'(WEIGHT0)};
    logic [1:0] cur_q, cur_d, arbiter_q, arbiter_d, sel, idx;
    logic [3:0] credit_q, credit_d, emp, elig, wt, pop;
    logic       valid_q, valid_d, cont, found, go;
    always_comb begin
        emp = {empty_vchanel3, empty_vchanel2, empty_vchanel1, empty_vchanel0};
        for (int i = 0; i < 4; i++) elig[i] = !emp[i] && (WTS[i*4 +: 4] != 4'd0);
        wt = WTS[{cur_q, 2'b00} +: 4];
        cont = elig[cur_q] && (credit_q < wt);
        sel = cur_q;
        idx = cur_q;
        found = 1'b0;
        // search wraps back to cur last, so a lone exhausted channel starts a new turn
        for (int k = 1; k < 5; k++) begin
            idx = cur_q + 2'(k);
            if (!found && elig[idx]) begin
                sel = idx;
                found = 1'b1;
            end
        end
        if (cont) sel = cur_q;
        go = !rst && enb && !stall && found;
        pop = go ? 4'b0001 << sel : 4'b0000;
        cur_d = go ? sel : cur_q;
        credit_d = !go ? credit_q : cont ? credit_q + 4'd1 : 4'd1;
        arbiter_d = go ? sel : arbiter_q;
        valid_d = go;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= 2'd0;
            credit_q <= 4'd0;
            arbiter_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            cur_q <= cur_d;
            credit_q <= credit_d;
            arbiter_q <= arbiter_d;
            valid_q <= valid_d;
        end
    end
    assign {pop_vchanel3, pop_vchanel2, pop_vchanel1, pop_vchanel0} = pop;
    assign arbiter = arbiter_q;
    assign valid = valid_q;
    assign grant_cnt = credit_q;
endmodule

// File: tb/tb_wrr_scheduler.sv
// tb_wrr_scheduler: directed steps with a queue of expected registered outputs
module tb_wrr_scheduler;
    logic       clk = 1'b0;
    logic       rst, enb, stall;
    logic [3:0] em;
    logic [3:0] pops;
    logic [1:0] arbiter;
    logic       valid;
    logic [3:0] grant_cnt;
    int         checks = 0;
    int         failures = 0;
    logic [1:0] last_arb = 2'd0;

    typedef struct packed {
        logic       v;
        logic [1:0] a;
        logic [3:0] c;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    wrr_scheduler dut (
        .clk(clk), .rst(rst), .enb(enb), .stall(stall),
        .empty_vchanel0(em[0]), .empty_vchanel1(em[1]),
        .empty_vchanel2(em[2]), .empty_vchanel3(em[3]),
        .pop_vchanel0(pops[0]), .pop_vchanel1(pops[1]),
        .pop_vchanel2(pops[2]), .pop_vchanel3(pops[3]),
        .arbiter(arbiter), .valid(valid), .grant_cnt(grant_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ep = expected popped channel (-1 none), ec = expected grant_cnt after this edge
    task automatic step(input logic r, input logic e, input logic s, input logic [3:0] emp,
                        input int ep, input int ec);
        exp_t x;
        @(negedge clk);
        rst = r; enb = e; stall = s; em = emp;
        #1;
        chk("pop", {4'd0, pops}, (ep < 0) ? 8'd0 : 8'(4'b0001 << ep));
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("valid", {7'd0, valid}, {7'd0, x.v});
            chk("arbiter", {6'd0, arbiter}, {6'd0, x.a});
            chk("grant_cnt", {4'd0, grant_cnt}, {4'd0, x.c});
        end
        if (r) begin
            last_arb = 2'd0;
            q.push_back('{1'b0, 2'd0, 4'd0});
        end else if (ep < 0) begin
            q.push_back('{1'b0, last_arb, 4'(ec)});
        end else begin
            last_arb = 2'(ep);
            q.push_back('{1'b1, 2'(ep), 4'(ec)});
        end
    endtask

    task automatic seq(input logic [3:0] emp, input int n, input int chs[], input int cns[]);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, emp, chs[i], cns[i]);
    endtask

    initial begin
        rst = 1'b1; enb = 1'b1; stall = 1'b0; em = 4'b0000;
        repeat (3) step(1'b1, 1'b1, 1'b0, 4'b0000, -1, 0);
        for (int r = 0; r < 2; r++)
            seq(4'b0000, 10, '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3}, '{1, 2, 3, 4, 1, 2, 3, 1, 2, 1});
        for (int r = 0; r < 2; r++)
            seq(4'b0010, 7, '{0, 0, 0, 0, 2, 2, 3}, '{1, 2, 3, 4, 1, 2, 1});
        seq(4'b1011, 4, '{2, 2, 2, 2}, '{1, 2, 1, 2});
        seq(4'b0000, 3, '{3, 0, 0}, '{1, 1, 2});
        seq(4'b0001, 4, '{1, 1, 1, 2}, '{1, 2, 3, 1});
        seq(4'b0000, 4, '{2, 3, 0, 0}, '{2, 1, 1, 2});
        repeat (3) step(1'b0, 1'b1, 1'b1, 4'b0000, -1, 2);
        seq(4'b0000, 10, '{0, 0, 1, 1, 1, 2, 2, 3, 0, 0}, '{3, 4, 1, 2, 3, 1, 2, 1, 1, 2});
        repeat (3) step(1'b0, 1'b0, 1'b0, 4'b0000, -1, 2);
        seq(4'b0000, 4, '{0, 0, 1, 1}, '{3, 4, 1, 2});
        step(1'b1, 1'b1, 1'b0, 4'b0000, -1, 0);
        seq(4'b0000, 5, '{0, 0, 0, 0, 1}, '{1, 2, 3, 4, 1});
        repeat (3) step(1'b0, 1'b1, 1'b0, 4'b1111, -1, 1);
        seq(4'b0000, 3, '{1, 1, 2}, '{2, 3, 1});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
